// File: rtl/ysyx_22041461_wbu_pkg.sv
// Write-back stage shared definitions:
// load funct3 encodings, FSM state encoding, default load timeout.
package ysyx_22041461_wbu_pkg;

    localparam logic [2:0] LB     = 3'b000;
    localparam logic [2:0] LH     = 3'b001;
    localparam logic [2:0] LW     = 3'b010;
    localparam logic [2:0] LD     = 3'b011;
    localparam logic [2:0] LBU    = 3'b100;
    localparam logic [2:0] LHU    = 3'b101;
    localparam logic [2:0] LWU    = 3'b110;
    localparam logic [2:0] LT_ILL = 3'b111;

    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/ysyx_22041461_load_ext.sv
// Load data extractor: shifts the doubleword down by the byte offset
// (zero-filled) and sign/zero-extends per funct3.
// Ports: off_i (byte offset), ltype_i (funct3), rdata_i (aligned
//        doubleword) -> data_o (extended value), illegal_o (funct3 111).
module ysyx_22041461_load_ext
    import ysyx_22041461_wbu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      off_i,
    input  logic [2:0]      ltype_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o,
    output logic            illegal_o
);

    logic [XLEN-1:0] s;

    // Bytes past the end of the doubleword read as zero.
    assign s = rdata_i >> {off_i, 3'b000};

    always_comb begin
        data_o    = '0;
        illegal_o = 1'b0;
        unique case (ltype_i)
            LB:     data_o = {{(XLEN-8){s[7]}}, s[7:0]};
            LH:     data_o = {{(XLEN-16){s[15]}}, s[15:0]};
            LW:     data_o = {{(XLEN-32){s[31]}}, s[31:0]};
            LD:     data_o = s;
            LBU:    data_o = {{(XLEN-8){1'b0}}, s[7:0]};
            LHU:    data_o = {{(XLEN-16){1'b0}}, s[15:0]};
            LWU:    data_o = {{(XLEN-32){1'b0}}, s[31:0]};
            LT_ILL: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_22041461_wbu.sv
// Write-back stage: accepts one retiring instruction per handshake,
// waits (with timeout) for load data, drives a one-cycle rf write and
// commit pulse. All outputs except in_ready are registered.
// Ports: clk/rst (async active-low), in_* upstream bundle, mem_rvalid/
//        mem_rdata load response, rf_* write port, commit_*, sticky err_*.
module ysyx_22041461_wbu
    import ysyx_22041461_wbu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wen,
    input  logic            in_is_load,
    input  logic [2:0]      in_load_type,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_result,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic            err_timeout,
    output logic            err_illegal
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e          state_q;
    logic [7:0]      cnt_q;
    logic [XLEN-1:0] pc_q;
    logic [4:0]      rd_q;
    logic            rd_wen_q;
    logic [2:0]      lt_q;
    logic [2:0]      off_q;

    logic            commit_valid_q;
    logic            rf_wen_q;
    logic [4:0]      rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;
    logic [XLEN-1:0] commit_pc_q;
    logic            err_timeout_q;
    logic            err_illegal_q;

    logic            accept;
    logic [XLEN-1:0] ext_data;
    logic            ext_illegal;
    logic            unused_addr;

    assign unused_addr = &{1'b0, in_addr[XLEN-1:3]};

    assign in_ready = (state_q != WAIT);
    assign accept   = in_valid & in_ready;

    ysyx_22041461_load_ext #(
        .XLEN(XLEN)
    ) u_load_ext (
        .off_i    (off_q),
        .ltype_i  (lt_q),
        .rdata_i  (mem_rdata),
        .data_o   (ext_data),
        .illegal_o(ext_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            pc_q           <= '0;
            rd_q           <= '0;
            rd_wen_q       <= 1'b0;
            lt_q           <= '0;
            off_q          <= '0;
            commit_valid_q <= 1'b0;
            rf_wen_q       <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            commit_pc_q    <= '0;
            err_timeout_q  <= 1'b0;
            err_illegal_q  <= 1'b0;
        end else begin
            commit_valid_q <= 1'b0;
            rf_wen_q       <= 1'b0;
            case (state_q)
                IDLE, COMMIT: begin
                    if (accept) begin
                        pc_q     <= in_pc;
                        rd_q     <= in_rd;
                        rd_wen_q <= in_rd_wen;
                        lt_q     <= in_load_type;
                        off_q    <= in_addr[2:0];
                        if (in_is_load) begin
                            state_q <= WAIT;
                            cnt_q   <= '0;
                        end else begin
                            // Non-load retires on the very next cycle.
                            state_q        <= COMMIT;
                            commit_valid_q <= 1'b1;
                            rf_wen_q       <= in_rd_wen & (in_rd != 5'd0);
                            rf_waddr_q     <= in_rd;
                            rf_wdata_q     <= in_result;
                            commit_pc_q    <= in_pc;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        // Data arriving on the timeout cycle still wins.
                        state_q        <= COMMIT;
                        commit_valid_q <= 1'b1;
                        rf_wen_q       <= rd_wen_q & (rd_q != 5'd0)
                                          & ~ext_illegal;
                        rf_waddr_q     <= rd_q;
                        rf_wdata_q     <= ext_data;
                        commit_pc_q    <= pc_q;
                        if (ext_illegal) begin
                            err_illegal_q <= 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q        <= COMMIT;
                        commit_valid_q <= 1'b1;
                        rf_waddr_q     <= rd_q;
                        rf_wdata_q     <= '0;
                        commit_pc_q    <= pc_q;
                        err_timeout_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign commit_valid = commit_valid_q;
    assign rf_wen       = rf_wen_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign commit_pc    = commit_pc_q;
    assign err_timeout  = err_timeout_q;
    assign err_illegal  = err_illegal_q;

endmodule

// File: tb/tb_ysyx_22041461_wbu.sv
// Self-checking bench for the write-back stage: a table of directed
// vectors plus hand sequences for back-to-back, timeout and reset cases.
module tb_ysyx_22041461_wbu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic        in_is_load;
    logic [2:0]  in_load_type;
    logic [63:0] in_addr;
    logic [63:0] in_result;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic        err_timeout;
    logic        err_illegal;

    int errors = 0;
    int checks = 0;

    ysyx_22041461_wbu dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_rd       (in_rd),
        .in_rd_wen   (in_rd_wen),
        .in_is_load  (in_is_load),
        .in_load_type(in_load_type),
        .in_addr     (in_addr),
        .in_result   (in_result),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .commit_valid(commit_valid),
        .commit_pc   (commit_pc),
        .err_timeout (err_timeout),
        .err_illegal (err_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ld;
        logic [2:0]  lt;
        logic [63:0] addr;
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] res;
        logic [63:0] pc;
        int          wt;
        logic        ewen;
        logic [63:0] edata;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        tick();
    endtask

    task automatic drive(input logic ld, input logic [2:0] lt,
                         input logic [63:0] addr, input logic [4:0] rd,
                         input logic wen, input logic [63:0] res,
                         input logic [63:0] pc);
        in_valid     = 1'b1;
        in_is_load   = ld;
        in_load_type = lt;
        in_addr      = addr;
        in_rd        = rd;
        in_rd_wen    = wen;
        in_result    = res;
        in_pc        = pc;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("v%0d", idx);
        drive(v.ld, v.lt, v.addr, v.rd, v.wen, v.res, v.pc);
        tick();
        in_valid = 1'b0;
        if (v.ld) begin
            chk({nm, "_ready_wait"}, 64'(in_ready), 64'd0);
            for (int k = 0; k < v.wt; k++) begin
                tick();
                chk({nm, "_nocommit"}, 64'(commit_valid), 64'd0);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            tick();
            mem_rvalid = 1'b0;
        end
        chk({nm, "_commit_valid"}, 64'(commit_valid), 64'd1);
        chk({nm, "_rf_wen"}, 64'(rf_wen), 64'(v.ewen));
        chk({nm, "_rf_waddr"}, 64'(rf_waddr), 64'(v.rd));
        chk({nm, "_rf_wdata"}, rf_wdata, v.edata);
        chk({nm, "_commit_pc"}, commit_pc, v.pc);
        chk({nm, "_ready_commit"}, 64'(in_ready), 64'd1);
        tick();
        chk({nm, "_idle_valid"}, 64'(commit_valid), 64'd0);
        chk({nm, "_idle_wen"}, 64'(rf_wen), 64'd0);
    endtask

    initial begin
        int n;
        rst          = 1'b0;
        in_valid     = 1'b0;
        in_pc        = '0;
        in_rd        = '0;
        in_rd_wen    = 1'b0;
        in_is_load   = 1'b0;
        in_load_type = '0;
        in_addr      = '0;
        in_result    = '0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;

        tv[0]  = '{1'b0, 3'b000, 64'h0, 64'h0, 5'd5, 1'b1,
                   64'h1234, 64'h8000_0000, 0, 1'b1, 64'h1234};
        tv[1]  = '{1'b1, 3'b000, 64'h3, 64'h0000_0000_80FF_0000, 5'd6,
                   1'b1, 64'hBAD, 64'h8000_0004, 4, 1'b1,
                   64'hFFFF_FFFF_FFFF_FF80};
        tv[2]  = '{1'b1, 3'b100, 64'h3, 64'h0000_0000_80FF_0000, 5'd6,
                   1'b1, 64'hBAD, 64'h8000_0008, 4, 1'b1, 64'h80};
        tv[3]  = '{1'b1, 3'b110, 64'h1004, 64'hDEAD_BEEF_0000_0000, 5'd7,
                   1'b1, 64'hBAD, 64'h8000_000C, 1, 1'b1,
                   64'h0000_0000_DEAD_BEEF};
        tv[4]  = '{1'b1, 3'b010, 64'h1004, 64'hDEAD_BEEF_0000_0000, 5'd8,
                   1'b1, 64'hBAD, 64'h8000_0010, 0, 1'b1,
                   64'hFFFF_FFFF_DEAD_BEEF};
        tv[5]  = '{1'b1, 3'b011, 64'h2000, 64'h0123_4567_89AB_CDEF, 5'd9,
                   1'b1, 64'hBAD, 64'h8000_0014, 2, 1'b1,
                   64'h0123_4567_89AB_CDEF};
        tv[6]  = '{1'b1, 3'b001, 64'h6, 64'h8001_0000_0000_0000, 5'd10,
                   1'b1, 64'hBAD, 64'h8000_0018, 0, 1'b1,
                   64'hFFFF_FFFF_FFFF_8001};
        tv[7]  = '{1'b1, 3'b101, 64'h2, 64'h0000_0000_F00D_0000, 5'd11,
                   1'b1, 64'hBAD, 64'h8000_001C, 1, 1'b1, 64'hF00D};
        tv[8]  = '{1'b1, 3'b010, 64'h6, 64'hAABB_0000_0000_0000, 5'd12,
                   1'b1, 64'hBAD, 64'h8000_0020, 0, 1'b1, 64'hAABB};
        tv[9]  = '{1'b1, 3'b011, 64'h7, 64'hFF00_0000_0000_0000, 5'd13,
                   1'b1, 64'hBAD, 64'h8000_0024, 3, 1'b1, 64'hFF};
        tv[10] = '{1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 1'b1,
                   64'h5555, 64'h8000_0028, 0, 1'b0, 64'h5555};
        tv[11] = '{1'b0, 3'b000, 64'h0, 64'h0, 5'd7, 1'b0,
                   64'h7777, 64'h8000_002C, 0, 1'b0, 64'h7777};
        tv[12] = '{1'b1, 3'b111, 64'h0, 64'h1111_2222_3333_4444, 5'd14,
                   1'b1, 64'hBAD, 64'h8000_0030, 1, 1'b0, 64'h0};

        #2;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_rf_wen", 64'(rf_wen), 64'd0);
        chk("rst_rf_wdata", rf_wdata, 64'd0);
        chk("rst_commit_pc", commit_pc, 64'd0);
        chk("rst_err_timeout", 64'(err_timeout), 64'd0);
        chk("rst_err_illegal", 64'(err_illegal), 64'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_vec(tv[i], i);
        end
        chk("ill_before", 64'(err_illegal), 64'd0);
        run_vec(tv[12], 12);
        chk("ill_sticky", 64'(err_illegal), 64'd1);
        chk("ill_no_timeout", 64'(err_timeout), 64'd0);

        // Three back-to-back non-loads.
        do_reset();
        drive(1'b0, 3'b0, 64'h0, 5'd1, 1'b1, 64'hA1, 64'h100);
        tick();
        chk("b2b0_valid", 64'(commit_valid), 64'd1);
        chk("b2b0_pc", commit_pc, 64'h100);
        chk("b2b0_ready", 64'(in_ready), 64'd1);
        drive(1'b0, 3'b0, 64'h0, 5'd2, 1'b1, 64'hA2, 64'h104);
        tick();
        chk("b2b1_valid", 64'(commit_valid), 64'd1);
        chk("b2b1_data", rf_wdata, 64'hA2);
        chk("b2b1_ready", 64'(in_ready), 64'd1);
        drive(1'b0, 3'b0, 64'h0, 5'd3, 1'b1, 64'hA3, 64'h108);
        tick();
        in_valid = 1'b0;
        chk("b2b2_valid", 64'(commit_valid), 64'd1);
        chk("b2b2_waddr", 64'(rf_waddr), 64'd3);
        chk("b2b2_pc", commit_pc, 64'h108);
        tick();
        chk("b2b_end_valid", 64'(commit_valid), 64'd0);

        // Load timeout: commit lands TIMEOUT edges after the accept.
        drive(1'b1, 3'b010, 64'h0, 5'd3, 1'b1, 64'hBAD, 64'h200);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (commit_valid !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("to_cycles", 64'(n), 64'd255);
        chk("to_valid", 64'(commit_valid), 64'd1);
        chk("to_rf_wen", 64'(rf_wen), 64'd0);
        chk("to_rf_wdata", rf_wdata, 64'd0);
        chk("to_pc", commit_pc, 64'h200);
        chk("to_err", 64'(err_timeout), 64'd1);
        tick();
        chk("to_err_sticky", 64'(err_timeout), 64'd1);

        // rvalid on the final waiting cycle beats the timeout.
        do_reset();
        drive(1'b1, 3'b011, 64'h0, 5'd4, 1'b1, 64'hBAD, 64'h300);
        tick();
        in_valid = 1'b0;
        repeat (254) tick();
        chk("last_nocommit", 64'(commit_valid), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hCAFE_F00D_1234_5678;
        tick();
        mem_rvalid = 1'b0;
        chk("last_valid", 64'(commit_valid), 64'd1);
        chk("last_wen", 64'(rf_wen), 64'd1);
        chk("last_data", rf_wdata, 64'hCAFE_F00D_1234_5678);
        chk("last_err", 64'(err_timeout), 64'd0);
        tick();

        // Reset in the middle of WAIT drops the load.
        drive(1'b1, 3'b011, 64'h0, 5'd5, 1'b1, 64'hBAD, 64'h400);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_wait_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_valid", 64'(commit_valid), 64'd0);
        chk("arst_wdata", rf_wdata, 64'd0);
        chk("arst_pc", commit_pc, 64'd0);
        #2;
        rst = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h1;
        tick();
        mem_rvalid = 1'b0;
        chk("late_rvalid_valid", 64'(commit_valid), 64'd0);
        chk("late_rvalid_wen", 64'(rf_wen), 64'd0);
        tick();
        chk("late_rvalid_after", 64'(commit_valid), 64'd0);
        chk("late_ready", 64'(in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22041461_wbu.md
Name: ysyx_22041461_wbu

Overview:
Write-back stage directly downstream of the MEM stage. It accepts one retiring instruction per handshake, waits for load data when needed, and aligns and sign/zero-extends that data. It then drives a single-cycle register-file write and a commit pulse. It also adds a multi-cycle memory-response wait with a timeout, which the MEM stage needs once reads stop being combinational.

Parameters:
XLEN, 64, datapath width
TIMEOUT, 255, max cycles waiting for mem_rvalid before the load is aborted (8-bit counter)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  WBU can accept this cycle
in_pc  in  64  pc of instruction
in_rd  in  5  destination register index
in_rd_wen  in  1  instruction writes rd
in_is_load  in  1  result comes from memory
in_load_type  in  3  funct3: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu, 111 illegal
in_addr  in  64  load byte address (offset = in_addr[2:0])
in_result  in  64  ALU/snpc result for non-loads
mem_rvalid  in  1  load data valid pulse from MEM
mem_rdata  in  64  8-byte-aligned doubleword containing the load
rf_wen  out  1  register-file write strobe
rf_waddr  out  5  register index
rf_wdata  out  64  write data
commit_valid  out  1  instruction retired this cycle
commit_pc  out  64  pc of retired instruction
err_timeout  out  1  sticky: a load timed out
err_illegal  out  1  sticky: load_type 111 seen

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, except in_ready=1; counter 0; sticky errors cleared. Reset during WAIT drops the pending load with no commit.
- States are IDLE, WAIT, COMMIT.
- in_ready = (state != WAIT). It is combinational from state only and never depends on in_valid.
- Accept occurs when in_valid & in_ready. The WBU then latches pc, rd, rd_wen, is_load, load_type, addr[2:0] and result.
- Accept of a non-load: next state COMMIT. rf_wdata = in_result.
- Accept of a load: next state WAIT. The counter is cleared.
- WAIT, mem_rvalid=1: rf_wdata = extended load data; next state COMMIT.
- WAIT, no rvalid: counter increments each cycle. When counter == TIMEOUT-1 with no rvalid, next state COMMIT with rf_wdata=0, rf_wen forced 0, and err_timeout set.
- COMMIT lasts one cycle:
  - commit_valid=1 and commit_pc = latched pc.
  - rf_wen = rd_wen & (rd != 0), except forced 0 on timeout or illegal type.
  - rf_waddr = rd.
  - Back-to-back: an accept in COMMIT goes to COMMIT or WAIT directly. Otherwise the next state is IDLE.
- All outputs are registered (driven from state/latches). commit_valid, rf_wen, rf_waddr, rf_wdata and commit_pc are only meaningful during COMMIT; commit_valid and rf_wen are 0 outside it.
- Latency:
  - Non-load accepted at edge N commits in cycle N+1.
  - Load whose rvalid is sampled at edge M commits in cycle M+1.
  - Throughput is 1 instruction/cycle for non-loads.
- mem_rvalid outside WAIT is ignored. mem_rvalid in the same cycle as the timeout edge wins: data is used and no error is raised.
- Load extraction:
  - s = mem_rdata >> (8*offset), zero-filled.
  - lb/lbu use s[7:0], lh/lhu use s[15:0], lw/lwu use s[31:0], ld uses s[63:0]; sign-extend or zero-extend per type.
  - Misaligned accesses crossing the doubleword use the zero-filled bytes, with no error.
  - Type 111: data 0, rf_wen forced 0, err_illegal set.

Decomposition:
- Package ysyx_22041461_wbu_pkg: load_type constants (LB..LWU, LT_ILL), state encoding (IDLE=2'd0, WAIT=2'd1, COMMIT=2'd2), TIMEOUT default.
- One combinational sub-module, ysyx_22041461_load_ext (offset, type, rdata -> data, illegal). It is instantiated in the WAIT capture path.

Test Plan:
- Non-load: in_valid, rd=5, result=0x1234, pc=0x80000000 -> next cycle commit_valid=1, rf_wen=1, rf_waddr=5, rf_wdata=0x1234, commit_pc=0x80000000.
- Load lb, addr offset 3, rdata=0x00000000_80FF0000 with byte3=0x80, rvalid after 4 cycles -> in_ready=0 for those cycles; commit with rf_wdata=0xFFFFFFFF_FFFFFF80. Repeat as lbu -> 0x80.
- Load lwu at offset 4, rdata=0xDEADBEEF_00000000 -> 0x00000000_DEADBEEF. lw -> 0xFFFFFFFF_DEADBEEF. ld at offset 0 -> full word.
- rd=0 with rd_wen=1 -> commit_valid=1, rf_wen=0. Three back-to-back non-loads -> three consecutive commit pulses, in_ready held 1.
- Load with no rvalid -> commit after TIMEOUT cycles with rf_wen=0, err_timeout=1 sticky. rvalid on the final cycle -> normal commit, err_timeout=0.
- rst pulled low mid-WAIT -> outputs 0 immediately (async), in_ready=1. A late rvalid after release is ignored, with no commit.
